// File: rtl/cla_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_pipe : segmented carry-lookahead adder/subtractor, one SEG-bit        |
// |            segment per pipeline stage, global-stall valid/ready flow.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module cla_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             signed_ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG;

    logic             valid_q [NSEG];
    logic             carry_q [NSEG];
    logic [WIDTH-1:0] sum_q   [NSEG];
    logic [WIDTH-1:0] a_q     [NSEG];
    logic [WIDTH-1:0] b_q     [NSEG];
    logic             ovf_q;
    logic             zero_q;
    logic             w_advance;

    // Every carry is a flat sum-of-products of g/p terms and the segment carry-in.
    function automatic logic [SEG:0] cla_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    assign w_advance = ~valid_q[NSEG-1] | out_ready;
    assign in_ready  = w_advance;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH-1:0] w_s_in;
        logic [WIDTH-1:0] w_s_out;
        logic             w_c;
        logic             w_v;
        logic [SEG:0]     w_seg;

        if (k == 0) begin : g_head
            assign w_a    = A;
            assign w_b    = sub ? ~B : B;
            assign w_c    = sub | Cin;
            // Loads only happen on advance, where in_ready is 1.
            assign w_v    = in_valid;
            assign w_s_in = '0;
        end else begin : g_body
            assign w_a    = a_q[k-1];
            assign w_b    = b_q[k-1];
            assign w_c    = carry_q[k-1];
            assign w_v    = valid_q[k-1];
            assign w_s_in = sum_q[k-1];
        end

        assign w_seg = cla_add(w_a[k*SEG +: SEG], w_b[k*SEG +: SEG], w_c);

        always_comb begin
            w_s_out                = w_s_in;
            w_s_out[k*SEG +: SEG]  = w_seg[SEG-1:0];
        end

        // Invalid slots carry zeros so the final stage presents 0 when idle.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
            end else if (w_advance) begin
                valid_q[k] <= w_v;
                carry_q[k] <= w_v & w_seg[SEG];
                sum_q[k]   <= w_v ? w_s_out : '0;
                a_q[k]     <= w_a;
                b_q[k]     <= w_b;
            end
        end

        if (k == NSEG - 1) begin : g_tail
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (w_advance) begin
                    ovf_q  <= w_v & (w_a[WIDTH-1] == w_b[WIDTH-1])
                                  & (w_s_out[WIDTH-1] != w_a[WIDTH-1]);
                    zero_q <= w_v & (w_s_out == '0);
                end
            end
        end
    end

    assign out_valid  = valid_q[NSEG-1];
    assign Sum        = sum_q[NSEG-1];
    assign Cout       = carry_q[NSEG-1];
    assign signed_ovf = ovf_q;
    assign zero       = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cla_pipe : scoreboard bench for cla_pipe (WIDTH=32, SEG=8).            |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_cla_pipe;
    localparam int WIDTH = 32;
    localparam int SEG   = 8;
    localparam int NSEG  = WIDTH / SEG;

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
        int          acc;
        bit          exact;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Sum;
    logic        Cout;
    logic        signed_ovf;
    logic        zero;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    cla_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .Sum(Sum), .Cout(Cout), .signed_ovf(signed_ovf),
        .zero(zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input string detail);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic s);
        exp_t        e;
        logic [63:0] r;
        longint      sa;
        longint      sbv;
        longint      sr;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (s) begin
            r    = {32'd0, a} - {32'd0, b};
            e.co = (a >= b);
            sr   = sa - sbv;
        end else begin
            r    = {32'd0, a} + {32'd0, b} + {63'd0, c};
            e.co = r[32];
            sr   = sa + sbv + longint'(c);
        end
        e.s     = r[31:0];
        e.ov    = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z     = (r[31:0] == 32'd0);
        e.acc   = 0;
        e.exact = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] s, input logic co,
                                input logic ov, input logic z);
        exp_t e;
        e.s = s; e.co = co; e.ov = ov; e.z = z; e.acc = 0; e.exact = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic c, input logic s, input logic rdy,
                               input exp_t e, output bit acc);
        @(negedge clk);
        in_valid  = v;
        A         = a;
        B         = b;
        Cin       = c;
        sub       = s;
        out_ready = rdy;
        #2;
        acc = v && in_ready && reset_n;
        if (acc) begin
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input exp_t e, input bit exact);
        bit acc;
        int tries;
        tries   = 0;
        e.exact = exact;
        do begin
            drive_cycle(1'b1, a, b, c, s, 1'b1, e, acc);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) chk(1'b0, "send_timeout", $sformatf("got no accept, required accept within 20 cycles"));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0), acc);
    endtask

    // Monitor: pops and compares on every output handshake, checks hold/idle rules.
    initial begin : monitor
        exp_t        e;
        logic [34:0] held;
        bit          hold_pend;
        hold_pend = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            #3;
            chk(in_ready === (!out_valid || out_ready), "in_ready",
                $sformatf("got %b required %b", in_ready, !out_valid || out_ready));
            if (out_valid !== 1'b1)
                chk({Sum, Cout, signed_ovf, zero} === 35'd0, "idle_outputs_zero",
                    $sformatf("got %h/%b/%b/%b required 0", Sum, Cout, signed_ovf, zero));
            if (hold_pend) begin
                chk({Sum, Cout, signed_ovf, zero} === held && out_valid === 1'b1, "stall_hold",
                    $sformatf("got %h required %h", {Sum, Cout, signed_ovf, zero}, held));
                hold_pend = 1'b0;
            end
            if (!reset_n) begin
                sb.delete();
            end else if (out_valid === 1'b1) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk(1'b0, "spurious_out", $sformatf("got Sum=%h with nothing outstanding, required none", Sum));
                    end else begin
                        e = sb.pop_front();
                        chk({Sum, Cout, signed_ovf, zero} === {e.s, e.co, e.ov, e.z}, "result",
                            $sformatf("got %h/%b/%b/%b required %h/%b/%b/%b",
                                      Sum, Cout, signed_ovf, zero, e.s, e.co, e.ov, e.z));
                        if (e.exact)
                            chk(cyc - e.acc == NSEG, "latency",
                                $sformatf("got %0d required %0d", cyc - e.acc, NSEG));
                    end
                end else begin
                    held      = {Sum, Cout, signed_ovf, zero};
                    hold_pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        nerr++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : stim
        bit          acc;
        int          sent;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic        v;
        logic        r;

        reset_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(out_valid === 1'b0, "reset_out_valid", $sformatf("got %b required 0", out_valid));
        chk({Sum, Cout, signed_ovf, zero} === 35'd0, "reset_outputs",
            $sformatf("got %h/%b/%b/%b required 0", Sum, Cout, signed_ovf, zero));
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        chk(in_ready === 1'b1, "in_ready_after_reset", $sformatf("got %b required 1", in_ready));

        // Directed corner vectors, streamed back-to-back with no stalls.
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0100, 0, 0, 0), 1'b1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h8000_0000, 0, 1, 0), 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, mk(32'h7FFF_FFFF, 1, 1, 0), 1'b1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'h0000_0000, 1, 0, 1), 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, mk(32'h0000_0001, 0, 0, 0), 1'b1);
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, mk(32'h0000_0000, 1, 0, 1), 1'b1);
        send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, mk(32'hFFFF_FFFF, 0, 0, 0), 1'b1);
        idle(8);

        // Eight back-to-back operands with the consumer stalled in cycles 6..9.
        sent = 0;
        for (int i = 1; i <= 30 && sent < 8; i++) begin
            a = pick(); b = pick(); c = 1'(($urandom() & 1)); s = 1'(($urandom() & 1));
            r = !(i >= 6 && i <= 9);
            drive_cycle(1'b1, a, b, c, s, r, model(a, b, c, s), acc);
            if (acc) sent++;
        end
        chk(sent == 8, "burst_accept", $sformatf("got %0d accepted required 8", sent));
        idle(12);

        // Reset with three operands in flight: none of them may emerge.
        for (int i = 0; i < 3; i++) begin
            a = pick(); b = pick();
            send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        reset_n  = 1'b1;
        idle(6);
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, mk(32'h2345_678A, 0, 0, 0), 1'b1);
        idle(8);

        // Random traffic with random producer/consumer throttling.
        for (int i = 0; i < 3000; i++) begin
            a = pick(); b = pick(); c = 1'(($urandom() & 1)); s = 1'(($urandom() & 1));
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            drive_cycle(v, a, b, c, s, r, model(a, b, c, s), acc);
        end
        idle(20);
        chk(sb.size() == 0, "drain", $sformatf("got %0d outstanding required 0", sb.size()));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
